// File: rtl/i2c_mem_arbiter.sv
// Arbitrates the single-port register RAM between the I2C memory sequencer and a local host.
// I2C has priority and may lock the RAM; a starvation counter and a release cycle keep the host moving.
module i2c_mem_arbiter #(
    parameter int ADDR_W       = 8,
    parameter int DATA_W       = 8,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_i2c_lock,
    input  logic              i_i2c_valid,
    input  logic              i_i2c_we,
    input  logic [ADDR_W-1:0] i_i2c_addr,
    input  logic [DATA_W-1:0] i_i2c_wdata,
    output logic              o_i2c_ready,
    output logic              o_i2c_rvalid,
    output logic [DATA_W-1:0] o_i2c_rdata,
    input  logic              i_host_valid,
    input  logic              i_host_we,
    input  logic [ADDR_W-1:0] i_host_addr,
    input  logic [DATA_W-1:0] i_host_wdata,
    output logic              o_host_ready,
    output logic              o_host_rvalid,
    output logic [DATA_W-1:0] o_host_rdata,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic [DATA_W-1:0] o_ram_wdata,
    output logic              o_ram_wren,
    input  logic [DATA_W-1:0] i_ram_rdata
);

    localparam logic [1:0] ARB_IDLE    = 2'd0;
    localparam logic [1:0] ARB_LOCKED  = 2'd1;
    localparam logic [1:0] ARB_RELEASE = 2'd2;
    localparam logic [3:0] LP_LIMIT    = 4'(STARVE_LIMIT);

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [3:0]        r_starve;
    logic [3:0]        w_starve_nxt;
    logic              r_pend;
    logic              r_owner_host;
    logic              r_i2c_rvalid;
    logic              r_host_rvalid;
    logic [DATA_W-1:0] r_i2c_rdata;
    logic [DATA_W-1:0] r_host_rdata;
    logic              w_i2c_gnt;
    logic              w_host_gnt;
    logic              w_rd_gnt;

    // Grant decision; the lock input acts in the same cycle, the FSM only adds the release preference
    always_comb begin
        w_i2c_gnt  = 1'b0;
        w_host_gnt = 1'b0;
        if (!rst_n) begin
            w_i2c_gnt  = 1'b0;
            w_host_gnt = 1'b0;
        end else if (i_i2c_lock) begin
            w_i2c_gnt = i_i2c_valid;
        end else if (r_state == ARB_RELEASE) begin
            w_host_gnt = i_host_valid;
            w_i2c_gnt  = !i_host_valid && i_i2c_valid;
        end else if (i_host_valid && (r_starve == LP_LIMIT)) begin
            w_host_gnt = 1'b1;
        end else if (i_i2c_valid) begin
            w_i2c_gnt = 1'b1;
        end else begin
            w_host_gnt = i_host_valid;
        end
    end

    // Next arbiter state from the lock input
    always_comb begin
        w_state_nxt = ARB_IDLE;
        case (r_state)
            ARB_IDLE:    w_state_nxt = i_i2c_lock ? ARB_LOCKED : ARB_IDLE;
            ARB_LOCKED:  w_state_nxt = i_i2c_lock ? ARB_LOCKED : ARB_RELEASE;
            ARB_RELEASE: w_state_nxt = i_i2c_lock ? ARB_LOCKED : ARB_IDLE;
            default:     w_state_nxt = ARB_IDLE;
        endcase
    end

    // Starvation counter: no request means no starvation, a lock only pauses the count
    always_comb begin
        w_starve_nxt = r_starve;
        if (w_host_gnt || !i_host_valid) begin
            w_starve_nxt = 4'd0;
        end else if (i_i2c_lock) begin
            w_starve_nxt = r_starve;
        end else if (r_starve < LP_LIMIT) begin
            w_starve_nxt = r_starve + 4'd1;
        end else begin
            w_starve_nxt = r_starve;
        end
    end

    // RAM port mux, parked at zero without a grant
    always_comb begin
        o_ram_addr  = '0;
        o_ram_wdata = '0;
        o_ram_wren  = 1'b0;
        case ({w_host_gnt, w_i2c_gnt})
            2'b01: begin
                o_ram_addr  = i_i2c_addr;
                o_ram_wdata = i_i2c_wdata;
                o_ram_wren  = i_i2c_we;
            end
            2'b10: begin
                o_ram_addr  = i_host_addr;
                o_ram_wdata = i_host_wdata;
                o_ram_wren  = i_host_we;
            end
            default: begin
                o_ram_addr  = '0;
                o_ram_wdata = '0;
                o_ram_wren  = 1'b0;
            end
        endcase
    end

    assign w_rd_gnt     = (w_i2c_gnt && !i_i2c_we) || (w_host_gnt && !i_host_we);
    assign o_i2c_ready  = w_i2c_gnt;
    assign o_host_ready = w_host_gnt;

    // Arbiter state and starvation counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ARB_IDLE;
            r_starve <= 4'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_starve <= w_starve_nxt;
        end
    end

    // Read return path: tag the owner at grant, capture RAM data one cycle later, pulse rvalid after that
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend        <= 1'b0;
            r_owner_host  <= 1'b0;
            r_i2c_rvalid  <= 1'b0;
            r_host_rvalid <= 1'b0;
            r_i2c_rdata   <= '0;
            r_host_rdata  <= '0;
        end else begin
            r_pend        <= w_rd_gnt;
            r_owner_host  <= w_host_gnt;
            r_i2c_rvalid  <= r_pend && !r_owner_host;
            r_host_rvalid <= r_pend && r_owner_host;
            if (r_pend && !r_owner_host) begin
                r_i2c_rdata <= i_ram_rdata;
            end
            if (r_pend && r_owner_host) begin
                r_host_rdata <= i_ram_rdata;
            end
        end
    end

    assign o_i2c_rvalid  = r_i2c_rvalid;
    assign o_i2c_rdata   = r_i2c_rdata;
    assign o_host_rvalid = r_host_rvalid;
    assign o_host_rdata  = r_host_rdata;

endmodule

// File: tb/tb_i2c_mem_arbiter.sv
// Scoreboard bench for i2c_mem_arbiter: a cycle-level arbitration model predicts grants and RAM
// traffic, expected read returns are queued per requester and checked by an independent monitor.
module tb_i2c_mem_arbiter;

    localparam int LIMIT = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       i2c_lock, i2c_valid, i2c_we, host_valid, host_we;
    logic [7:0] i2c_addr, i2c_wdata, host_addr, host_wdata;
    logic       i2c_ready, i2c_rvalid, host_ready, host_rvalid, ram_wren;
    logic [7:0] i2c_rdata, host_rdata, ram_addr, ram_wdata, ram_rdata;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    typedef struct {
        logic [7:0] d;
        int         due;
    } rd_t;

    rd_t        q_i2c[$];
    rd_t        q_host[$];
    logic [7:0] exp_i2c_rdata = 8'h00;
    logic [7:0] exp_host_rdata = 8'h00;

    // reference state: memory contents, lock history of the last two cycles, starvation count
    logic [7:0] m_mem [0:255];
    logic       m_l1 = 1'b0;
    logic       m_l2 = 1'b0;
    int         m_starve = 0;

    logic [7:0] ram_mem [0:255];

    i2c_mem_arbiter #(.ADDR_W(8), .DATA_W(8), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_i2c_lock(i2c_lock), .i_i2c_valid(i2c_valid), .i_i2c_we(i2c_we),
        .i_i2c_addr(i2c_addr), .i_i2c_wdata(i2c_wdata),
        .o_i2c_ready(i2c_ready), .o_i2c_rvalid(i2c_rvalid), .o_i2c_rdata(i2c_rdata),
        .i_host_valid(host_valid), .i_host_we(host_we),
        .i_host_addr(host_addr), .i_host_wdata(host_wdata),
        .o_host_ready(host_ready), .o_host_rvalid(host_rvalid), .o_host_rdata(host_rdata),
        .o_ram_addr(ram_addr), .o_ram_wdata(ram_wdata), .o_ram_wren(ram_wren),
        .i_ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // synchronous RAM macro stand-in
    always @(posedge clk) begin
        if (ram_wren) ram_mem[ram_addr] <= ram_wdata;
        ram_rdata <= ram_mem[ram_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // one clock cycle: drive, check grants and RAM port against the model, update the model
    task automatic step(input logic rst, input logic lk,
                        input logic iv, input logic iwe, input logic [7:0] ia, input logic [7:0] iwd,
                        input logic hv, input logic hwe, input logic [7:0] ha, input logic [7:0] hwd);
        logic eg_i, eg_h, rel;
        logic [7:0] e_addr, e_wd;
        logic e_wren;
        rd_t r;
        @(negedge clk);
        rst_n = rst; i2c_lock = lk;
        i2c_valid = iv; i2c_we = iwe; i2c_addr = ia; i2c_wdata = iwd;
        host_valid = hv; host_we = hwe; host_addr = ha; host_wdata = hwd;
        eg_i = 1'b0; eg_h = 1'b0;
        if (!rst) begin
            m_l1 = 1'b0; m_l2 = 1'b0; m_starve = 0;
            q_i2c.delete(); q_host.delete();
            exp_i2c_rdata = 8'h00; exp_host_rdata = 8'h00;
        end else begin
            rel = !m_l1 && m_l2;
            if (lk) eg_i = iv;
            else if (rel) begin eg_h = hv; eg_i = !hv && iv; end
            else if (hv && m_starve == LIMIT) eg_h = 1'b1;
            else if (iv) eg_i = 1'b1;
            else eg_h = hv;
        end
        e_addr = eg_i ? ia : (eg_h ? ha : 8'h00);
        e_wd   = eg_i ? iwd : (eg_h ? hwd : 8'h00);
        e_wren = eg_i ? iwe : (eg_h ? hwe : 1'b0);
        #1;
        chk("i2c_ready", i2c_ready, eg_i);
        chk("host_ready", host_ready, eg_h);
        chk("ram_wren", ram_wren, e_wren);
        chk("ram_addr", ram_addr, e_addr);
        chk("ram_wdata", ram_wdata, e_wd);
        if (rst) begin
            if (eg_h || !hv) m_starve = 0;
            else if (!lk && m_starve < LIMIT) m_starve++;
            if (e_wren) m_mem[e_addr] = e_wd;
            else if (eg_i || eg_h) begin
                r.d = m_mem[e_addr];
                r.due = cyc + 2;
                if (eg_i) q_i2c.push_back(r);
                else q_host.push_back(r);
            end
            m_l2 = m_l1; m_l1 = lk;
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    endtask

    // monitor: pops expected read returns when the DUT presents rvalid, checks held rdata every cycle
    always @(negedge clk) begin
        rd_t e;
        #2;
        if (i2c_rvalid) begin
            if (q_i2c.size() == 0) chk("i2c_rvalid_unexpected", 1, 0);
            else begin
                e = q_i2c.pop_front();
                chk("i2c_rvalid_time", cyc, e.due);
                exp_i2c_rdata = e.d;
            end
        end else if (q_i2c.size() > 0 && q_i2c[0].due <= cyc) begin
            chk("i2c_rvalid_missing", 0, 1);
            void'(q_i2c.pop_front());
        end
        if (host_rvalid) begin
            if (q_host.size() == 0) chk("host_rvalid_unexpected", 1, 0);
            else begin
                e = q_host.pop_front();
                chk("host_rvalid_time", cyc, e.due);
                exp_host_rdata = e.d;
            end
        end else if (q_host.size() > 0 && q_host[0].due <= cyc) begin
            chk("host_rvalid_missing", 0, 1);
            void'(q_host.pop_front());
        end
        chk("i2c_rdata", i2c_rdata, exp_i2c_rdata);
        chk("host_rdata", host_rdata, exp_host_rdata);
    end

    initial begin
        logic lk;
        for (int a = 0; a < 256; a++) m_mem[a] = 8'h00;
        rst_n = 1'b0; i2c_lock = 1'b0; i2c_valid = 1'b0; i2c_we = 1'b0; i2c_addr = 8'h00;
        i2c_wdata = 8'h00; host_valid = 1'b0; host_we = 1'b0; host_addr = 8'h00; host_wdata = 8'h00;

        // reset state
        for (int k = 0; k < 2; k++) step(1'b0, 1'b0, 1'b1, 1'b1, 8'h33, 8'h44, 1'b1, 1'b0, 8'h55, 8'h66);
        idle(5);

        // write then read from the I2C side
        step(1'b1, 1'b0, 1'b1, 1'b1, 8'h10, 8'hA5, 1'b0, 1'b0, 8'h00, 8'h00);
        step(1'b1, 1'b0, 1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        idle(2);
        chk("wr_rd_rvalid", i2c_rvalid, 1'b1);
        chk("wr_rd_data", i2c_rdata, 8'hA5);
        chk("wr_rd_host_rvalid", host_rvalid, 1'b0);

        // interleaved reads
        step(1'b1, 1'b0, 1'b1, 1'b1, 8'h01, 8'h11, 1'b0, 1'b0, 8'h00, 8'h00);
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h02, 8'h22);
        step(1'b1, 1'b0, 1'b1, 1'b0, 8'h01, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h02, 8'h00);
        idle(1);
        chk("ilv_i2c_rvalid", i2c_rvalid, 1'b1);
        chk("ilv_i2c_data", i2c_rdata, 8'h11);
        idle(1);
        chk("ilv_host_rvalid", host_rvalid, 1'b1);
        chk("ilv_host_data", host_rdata, 8'h22);
        chk("ilv_i2c_hold", i2c_rdata, 8'h11);

        // contention: host wins exactly on the fifth cycle
        for (int k = 0; k < 6; k++) begin
            step(1'b1, 1'b0, 1'b1, 1'b1, 8'h20, 8'(k), 1'b1, 1'b1, 8'h21, 8'(k));
            chk("contend_host", host_ready, (k == 4));
            chk("contend_i2c", i2c_ready, (k != 4));
        end
        idle(2);

        // lock for ten cycles, release cycle favours host
        for (int k = 0; k < 13; k++) begin
            step(1'b1, (k < 10), 1'b1, 1'b1, 8'h30, 8'h00, 1'b1, 1'b1, 8'h31, 8'h00);
            if (k < 10) chk("lock_host_blocked", host_ready, 1'b0);
            if (k == 11) chk("release_host", host_ready, 1'b1);
        end
        idle(2);

        // reset in the middle of a read
        step(1'b1, 1'b0, 1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        chk("rst_i2c_rvalid", i2c_rvalid, 1'b0);
        chk("rst_i2c_rdata", i2c_rdata, 8'h00);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        idle(4);

        // preload the random address window
        for (int a = 0; a < 16; a++) step(1'b1, 1'b0, 1'b1, 1'b1, 8'(a), 8'($urandom), 1'b0, 1'b0, 8'h00, 8'h00);

        // random traffic with lock episodes
        lk = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 11) == 0) lk = !lk;
            step(1'b1, lk,
                 ($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1, 8'($urandom_range(0, 15)), 8'($urandom),
                 ($urandom_range(0, 2) != 0), $urandom_range(0, 1) == 1, 8'($urandom_range(0, 15)), 8'($urandom));
        end
        idle(4);
        chk("drain_i2c", q_i2c.size(), 0);
        chk("drain_host", q_host.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/i2c_mem_arbiter.md
# i2c_mem_arbiter

Shares the single-port register RAM between the I2C subordinate memory sequencer and a local host port. Each cycle it grants at most one access. The I2C side has priority, and it can lock the RAM for a whole I2C transaction so the bus-side ACK timing is never stalled. A saturating starvation counter and a post-lock release cycle guarantee the host forward progress. The block sits between the memory state machine datapath (address/data registers, wren, read strobe) and the RAM macro.

## Interface
- ADDR_W, 8, RAM address width
- DATA_W, 8, RAM data width
- STARVE_LIMIT, 4, consecutive blocked host cycles (unlocked) before host overrides I2C; range 1..15
- clk  in  1  single clock, all state on posedge
- rst_n  in  1  reset, asynchronous, active-low
- i2c_lock  in  1  high for the duration of an I2C memory transaction; blocks host
- i2c_valid  in  1  I2C access request
- i2c_we  in  1  1 = write, 0 = read
- i2c_addr  in  ADDR_W  access address
- i2c_wdata  in  DATA_W  write data
- i2c_ready  out  1  grant; transfer when i2c_valid && i2c_ready
- i2c_rvalid  out  1  one-cycle pulse, i2c_rdata valid
- i2c_rdata  out  DATA_W  held read data
- host_valid, host_we, host_addr, host_wdata  in  1/1/ADDR_W/DATA_W  host request, same meaning as I2C
- host_ready  out  1  host grant
- host_rvalid  out  1  host read-data pulse
- host_rdata  out  DATA_W  held host read data
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  DATA_W  RAM write data
- ram_wren  out  1  RAM write enable
- ram_rdata  in  DATA_W  RAM read data, valid the cycle after the address is presented

## Operation
- FSM states: ARB_IDLE, ARB_LOCKED, ARB_RELEASE. State is register-only.
- ARB_IDLE -> ARB_LOCKED when i2c_lock=1.
- ARB_LOCKED -> ARB_RELEASE when i2c_lock=0.
- ARB_RELEASE -> ARB_LOCKED if i2c_lock=1, else ARB_IDLE (always exactly one cycle).
- Grant is combinational. At most one of i2c_ready/host_ready is high. A ready is never high without its valid.
- Any state with i2c_lock=1: host never granted; i2c granted if i2c_valid.
- ARB_IDLE, lock low: host wins if host_valid && starve_cnt==STARVE_LIMIT; otherwise i2c if i2c_valid; otherwise host if host_valid.
- ARB_RELEASE, lock low: host wins if host_valid; otherwise i2c.
- starve_cnt (4 bit) has three update rules:
  - Cleared when host is granted or host_valid=0.
  - Incremented, saturating at STARVE_LIMIT, when host_valid && !host_ready && i2c_lock=0.
  - Frozen while i2c_lock=1.
- RAM mux:
  - With a grant: ram_addr/ram_wdata come from the granted requester; ram_wren = granted we.
  - With no grant: ram_wren=0, ram_addr=0, ram_wdata=0.
- Read tracking: a granted read sets a one-bit owner tag plus a pending flag. On the next cycle the owner's rdata register captures ram_rdata, and that owner's rvalid pulses the following cycle.
- rdata registers hold their value until the next read completion for that requester. Writes never touch them.
- Back-to-back reads (to either requester) are allowed every cycle. The pending pipeline is one entry deep per stage.

## Timing
- Reset (rst_n low, async): FSM=ARB_IDLE, starve_cnt=0, pending flags=0, i2c_rvalid=host_rvalid=0, i2c_rdata=host_rdata=0. i2c_ready, host_ready and ram_wren are forced 0 while rst_n is low.
- Grant latency: 0 cycles (ready is high in the same cycle as valid when the requester wins).
- Write: the RAM is written at the clock edge that ends the grant cycle.
- Read: grant in cycle N, ram_rdata sampled at end of N+1, rvalid high in N+2. Total read latency is 2 cycles.
- The lock takes effect combinationally in the cycle i2c_lock rises. The FSM follows one edge later.
- Host worst-case wait while unlocked: STARVE_LIMIT cycles.
- Reset asserted mid-read: the pending read is discarded and no rvalid is issued after rst_n rises.
- Simultaneous valids with starve_cnt<STARVE_LIMIT and unlocked ARB_IDLE: I2C wins.

## Test plan
- Write then read, I2C only: write addr 0x10 data 0xA5 in cycle 0; read 0x10 in cycle 1 -> i2c_ready high both cycles; i2c_rvalid pulses in cycle 3 with i2c_rdata=0xA5; host_rvalid stays 0.
- Contention, unlocked, STARVE_LIMIT=4: both valid continuously -> i2c granted for cycles 0-3; host granted in cycle 4; starve_cnt=0 in cycle 5; I2C granted again in cycle 5.
- Lock: i2c_lock=1 for 10 cycles with host_valid=1 -> host_ready=0 throughout and starve_cnt unchanged. Lock drops in cycle 10 -> cycle 11 (ARB_RELEASE) grants host even though i2c_valid=1.
- Interleaved reads: I2C read 0x01 (holding 0x11) in cycle 0, host read 0x02 (holding 0x22) in cycle 1 -> i2c_rvalid in cycle 2 with 0x11; host_rvalid in cycle 3 with 0x22; each rdata holds its value afterwards.
- Reset mid-read: I2C read granted in cycle 0, rst_n low in cycle 1 -> all outputs 0; no rvalid ever follows; FSM is ARB_IDLE after rst_n rises.
- Idle: no valids for 5 cycles -> ram_wren=0, ram_addr=0, both readys 0, starve_cnt=0.
